// File: rtl/clk_div_mc_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_mc_pkg
// Shared constants and helpers for the multi-channel clock divider.
//   DEFAULT_WIDTH : default counter/divisor width
//   DEFAULT_DIV   : default reset divisor (period minus 1)
//   div_for()     : divisor for a wanted tick rate, for instantiating blocks
// Optional feature macro used by the divider: CLK_DIV_MC_SYNC_EN
// -----------------------------------------------------------------------------
package clk_div_mc_pkg;

  localparam int DEFAULT_WIDTH = 26;
  localparam int DEFAULT_DIV   = 49_999_999;

  // Divisor register value producing tick_hz from clk_hz (period minus 1).
  // A zero tick rate or a tick rate above the clock rate yields 0 (fastest).
  function automatic int unsigned div_for(input int unsigned clk_hz,
                                          input int unsigned tick_hz);
    int unsigned q;
    if (tick_hz == 32'd0) begin
      q = 32'd0;
    end else begin
      q = clk_hz / tick_hz;
    end
    if (q == 32'd0) begin
      return 32'd0;
    end else begin
      return q - 32'd1;
    end
  endfunction

endpackage

// File: rtl/clk_div_mc_ch.sv
// -----------------------------------------------------------------------------
// clk_div_mc_ch
// One divider channel: counter, active/shadow divisor, pending flag, square
// wave and tick decode. A written divisor waits in the shadow register and is
// adopted only at a wrap (or while the channel is disabled), so the running
// period is never cut short or stretched.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : channel enable
//   wr_en_i       : divisor write strobe addressed to this channel
//   wr_div_i      : new divisor (period = value + 1)
//   sync_i        : phase-align request (only with CLK_DIV_MC_SYNC_EN)
//   tick_o        : one-cycle pulse per period (decoded from registers)
//   sq_o          : toggles on every tick
//   pend_o        : shadow divisor written but not yet active
// Optional feature macro: CLK_DIV_MC_SYNC_EN
// -----------------------------------------------------------------------------
module clk_div_mc_ch
  import clk_div_mc_pkg::*;
#(
  parameter int Width      = DEFAULT_WIDTH,
  parameter int DefaultDiv = DEFAULT_DIV
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_div_i,
`ifdef CLK_DIV_MC_SYNC_EN
  input  logic             sync_i,
`endif
  output logic             tick_o,
  output logic             sq_o,
  output logic             pend_o
);

  localparam logic [Width-1:0] DIV_RST = Width'(DefaultDiv);

  logic [Width-1:0] cnt, cnt_nxt;
  logic [Width-1:0] active_div, active_nxt;
  logic [Width-1:0] shadow_div, shadow_nxt;
  logic             pend, pend_nxt;
  logic             sq, sq_nxt;
  logic             wrap;
  logic             sync_hit;
  logic             load_ok;
  logic [Width-1:0] load_div;

`ifdef CLK_DIV_MC_SYNC_EN
  assign sync_hit = sync_i;
`else
  assign sync_hit = 1'b0;
`endif

  // cnt never exceeds active_div because a new divisor only lands at a wrap
  assign wrap = (cnt == active_div);

  // At a wrap the newest divisor wins: a same-cycle write beats the shadow.
  assign load_ok  = wr_en_i | pend;
  assign load_div = wr_en_i ? wr_div_i : shadow_div;

  assign tick_o = en_i & wrap & ~sync_hit;
  assign sq_o   = sq;
  assign pend_o = pend;

  // Next-state decode for counter, divisors, pending flag and square wave
  always_comb begin
    cnt_nxt    = cnt;
    active_nxt = active_div;
    shadow_nxt = shadow_div;
    pend_nxt   = pend;
    sq_nxt     = sq;

    if (wr_en_i) begin
      shadow_nxt = wr_div_i;
      pend_nxt   = 1'b1;
    end else begin
      shadow_nxt = shadow_div;
    end

    if (!en_i) begin
      cnt_nxt = '0;
      sq_nxt  = 1'b0;
      // Only the already-pending shadow is adopted; a same-cycle write keeps
      // pend set and waits for the next disabled cycle or wrap.
      if (pend) begin
        active_nxt = shadow_div;
        pend_nxt   = wr_en_i;
      end else begin
        active_nxt = active_div;
      end
    end else if (sync_hit || wrap) begin
      cnt_nxt = '0;
      sq_nxt  = sync_hit ? 1'b0 : ~sq;
      if (load_ok) begin
        active_nxt = load_div;
        pend_nxt   = 1'b0;
      end else begin
        active_nxt = active_div;
      end
    end else begin
      cnt_nxt = cnt + Width'(1);
    end
  end

  // Channel state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt        <= '0;
      active_div <= DIV_RST;
      shadow_div <= DIV_RST;
      pend       <= 1'b0;
      sq         <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      active_div <= active_nxt;
      shadow_div <= shadow_nxt;
      pend       <= pend_nxt;
      sq         <= sq_nxt;
    end
  end

endmodule

// File: rtl/clk_div_mc.sv
// -----------------------------------------------------------------------------
// clk_div_mc
// Multi-channel runtime-programmable clock divider / tick generator. NumCh
// independent channels share one divisor write port; each has its own enable,
// tick pulse, square-wave output and pending flag.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : per-channel enable
//   wr_en_i       : divisor write strobe
//   wr_ch_i       : channel addressed by the write (>= NumCh is ignored)
//   wr_div_i      : new divisor (period = value + 1)
//   sync_i        : align all enabled channels (only with CLK_DIV_MC_SYNC_EN)
//   tick_o        : per-channel one-cycle tick
//   sq_o          : per-channel square wave
//   pend_o        : per-channel pending-divisor flag
// Optional feature macro: CLK_DIV_MC_SYNC_EN
// -----------------------------------------------------------------------------
module clk_div_mc
  import clk_div_mc_pkg::*;
#(
  parameter  int Width      = DEFAULT_WIDTH,
  parameter  int NumCh      = 4,
  parameter  int DefaultDiv = DEFAULT_DIV,
  localparam int ChW        = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumCh-1:0] en_i,
  input  logic             wr_en_i,
  input  logic [ChW-1:0]   wr_ch_i,
  input  logic [Width-1:0] wr_div_i,
`ifdef CLK_DIV_MC_SYNC_EN
  input  logic             sync_i,
`endif
  output logic [NumCh-1:0] tick_o,
  output logic [NumCh-1:0] sq_o,
  output logic [NumCh-1:0] pend_o
);

  logic [NumCh-1:0] wr_strobe;

  // Decode the shared write port into per-channel strobes; an address with no
  // matching channel produces no strobe, so out-of-range writes vanish.
  always_comb begin
    wr_strobe = '0;
    for (int c = 0; c < NumCh; c++) begin
      if (wr_en_i && (wr_ch_i == ChW'(c))) begin
        wr_strobe[c] = 1'b1;
      end else begin
        wr_strobe[c] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    clk_div_mc_ch #(
      .Width      (Width),
      .DefaultDiv (DefaultDiv)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (en_i[g]),
      .wr_en_i  (wr_strobe[g]),
      .wr_div_i (wr_div_i),
`ifdef CLK_DIV_MC_SYNC_EN
      .sync_i   (sync_i),
`endif
      .tick_o   (tick_o[g]),
      .sq_o     (sq_o[g]),
      .pend_o   (pend_o[g])
    );
  end

endmodule
